// File: rtl/softmax_row_prep.sv
// softmax_row_prep: scales serial Q5.10 scores, collects a 16-element row,
// subtracts the row maximum, clamps to the exp LUT floor and emits the row
// as one parallel vector with a single-cycle valid pulse.
module softmax_row_prep #(
   parameter int unsigned SCALE_SHIFT = 2,
   parameter logic [15:0] CLAMP_MIN   = 16'hE000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        valid_out,
   output logic [15:0] vector_out [0:15],
   output logic [7:0]  row_count
);

   localparam int unsigned DW    = 16;
   localparam int unsigned LANES = 16;
   localparam int unsigned CW    = 4;
   localparam int unsigned RCW   = 8;

   typedef enum logic {
      COLLECT = 1'b0,
      NORM    = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              accept_c;
   logic [DW-1:0]     scaled_c;
   logic [CW-1:0]     elem_cnt_q;
   logic [DW-1:0]     row_max_q;
   logic [DW-1:0]     elem_buf_q [LANES];
   logic [DW:0]       diff_c     [LANES];
   logic [DW-1:0]     vec_d      [LANES];
   logic [DW-1:0]     vec_q      [LANES];
   logic              valid_q;
   logic [RCW-1:0]    row_count_q;
   logic [DW:0]       clamp_ext_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   // Next-state and ready decode; NORM lasts exactly one cycle
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && (elem_cnt_q == CW'(LANES - 1))) state_d = NORM;
         end
         NORM:    state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // Handshake and sign-preserving 1/sqrt(d) scaling
   always_comb begin
      accept_c = in_valid && in_ready;
      scaled_c = DW'($signed(in_data) >>> SCALE_SHIFT);
   end

   // Element counter and running maximum; element 0 seeds the maximum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_cnt_q <= '0;
         row_max_q  <= '0;
      end else if (accept_c) begin
         elem_cnt_q <= elem_cnt_q + CW'(1);
         if ((elem_cnt_q == '0) || ($signed(scaled_c) > $signed(row_max_q)))
            row_max_q <= scaled_c;
      end
   end

   // Row buffer; contents are irrelevant until written, so no reset
   always_ff @(posedge clk) begin
      if (accept_c) elem_buf_q[elem_cnt_q] <= scaled_c;
   end

   // Max subtraction at 17 bits so the full-range difference cannot wrap
   always_comb begin
      clamp_ext_c = {CLAMP_MIN[DW-1], CLAMP_MIN};
      for (int i = 0; i < LANES; i++) begin
         diff_c[i] = {elem_buf_q[i][DW-1], elem_buf_q[i]} - {row_max_q[DW-1], row_max_q};
         vec_d[i]  = ($signed(diff_c[i]) < $signed(clamp_ext_c)) ? CLAMP_MIN
                                                                  : diff_c[i][DW-1:0];
      end
   end

   // Output vector, valid pulse and row counter, all captured at the NORM edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         row_count_q <= '0;
         for (int i = 0; i < LANES; i++) vec_q[i] <= '0;
      end else begin
         valid_q <= (state_q == NORM);
         if (state_q == NORM) begin
            row_count_q <= row_count_q + RCW'(1);
            for (int i = 0; i < LANES; i++) vec_q[i] <= vec_d[i];
         end
      end
   end

   assign valid_out = valid_q;
   assign row_count = row_count_q;
   assign vector_out = vec_q;

endmodule
